// File: rtl/tank_pkg.sv
// Shared tank-game constants: fixed-point format, screen bounds and shot FSM states.
package tank_pkg;
  localparam int FRAC_BITS = 6;
  localparam int POS_W     = 16;
  localparam int PIX_W     = 10;
  localparam int VEL_W     = 8;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  typedef enum logic {READY = 1'b0, COOLING = 1'b1} shot_state_t;

  // -128 has no positive counterpart in 8 bits, so it clamps to +127.
  function automatic logic signed [VEL_W-1:0] sat_neg(input logic signed [VEL_W-1:0] v);
    return (v == 8'sh80) ? 8'sh7f : -v;
  endfunction
endpackage

// File: rtl/bullet_slot.sv
// One bullet: 10.6 position, signed velocity, lifetime timer, wall bounce and off-screen kill.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int LIFETIME = 300
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    frame_tick,
  input  logic                    clear,
  input  logic                    spawn,
  input  logic [PIX_W-1:0]        spawn_x,
  input  logic [PIX_W-1:0]        spawn_y,
  input  logic signed [VEL_W-1:0] spawn_vx,
  input  logic signed [VEL_W-1:0] spawn_vy,
  input  logic [3:0]              wall_hit,
  output logic                    active,
  output logic [PIX_W-1:0]        bullet_x,
  output logic [PIX_W-1:0]        bullet_y
);
  localparam int TW = $clog2(LIFETIME + 1);
  localparam logic signed [17:0] X_MAX = 18'((SCREEN_W << FRAC_BITS) - 1);
  localparam logic signed [17:0] Y_MAX = 18'((SCREEN_H << FRAC_BITS) - 1);

  logic [POS_W-1:0]        pos_x, pos_y;
  logic signed [VEL_W-1:0] vx, vy, vx_eff, vy_eff;
  logic [TW-1:0]           timer, timer_dec;
  logic signed [17:0]      nx, ny;
  logic                    out_of_bounds;

  always_comb begin
    vx_eff        = (wall_hit[3] | wall_hit[2]) ? sat_neg(vx) : vx;
    vy_eff        = (wall_hit[1] | wall_hit[0]) ? sat_neg(vy) : vy;
    // Two extra bits so a step past either edge is visible as a sign or magnitude excursion.
    nx            = $signed({2'b00, pos_x}) + {{10{vx_eff[VEL_W-1]}}, vx_eff};
    ny            = $signed({2'b00, pos_y}) + {{10{vy_eff[VEL_W-1]}}, vy_eff};
    out_of_bounds = (nx < 18'sd0) || (nx > X_MAX) || (ny < 18'sd0) || (ny > Y_MAX);
    timer_dec     = timer - TW'(1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      active <= 1'b0;
      pos_x  <= '0;
      pos_y  <= '0;
      vx     <= '0;
      vy     <= '0;
      timer  <= '0;
    end else if (clear) begin
      active <= 1'b0;
    end else if (frame_tick) begin
      if (spawn) begin
        active <= 1'b1;
        pos_x  <= {spawn_x, {FRAC_BITS{1'b0}}};
        pos_y  <= {spawn_y, {FRAC_BITS{1'b0}}};
        vx     <= spawn_vx;
        vy     <= spawn_vy;
        timer  <= TW'(LIFETIME);
      end else if (active) begin
        // Bounced velocity is kept so the bullet continues in the reflected direction.
        vx    <= vx_eff;
        vy    <= vy_eff;
        pos_x <= nx[POS_W-1:0];
        pos_y <= ny[POS_W-1:0];
        timer <= timer_dec;
        if (timer_dec == '0 || out_of_bounds) active <= 1'b0;
      end
    end
  end

  assign bullet_x = pos_x[POS_W-1:FRAC_BITS];
  assign bullet_y = pos_y[POS_W-1:FRAC_BITS];
endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: lowest-free-slot allocation, shot cooldown FSM, round clear and slot array.
module bullet_pool
  import tank_pkg::*;
#(
  parameter int NUM_BULLETS = 3,
  parameter int LIFETIME    = 300,
  parameter int COOLDOWN    = 35
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          frame_tick,
  input  logic                          clear,
  input  logic                          fire,
  input  logic [PIX_W-1:0]              tank_x,
  input  logic [PIX_W-1:0]              tank_y,
  input  logic signed [VEL_W-1:0]       sin,
  input  logic signed [VEL_W-1:0]       cos,
  input  logic [NUM_BULLETS*4-1:0]      wall_hit,
  output logic [NUM_BULLETS*PIX_W-1:0]  bullet_x,
  output logic [NUM_BULLETS*PIX_W-1:0]  bullet_y,
  output logic [NUM_BULLETS-1:0]        active,
  output logic                          fire_ack,
  output logic [3:0]                    active_count
);
  localparam int CW = $clog2(COOLDOWN + 2);

  shot_state_t             state;
  logic [CW-1:0]           cooldown;
  logic [NUM_BULLETS-1:0]  free_onehot, spawn;
  logic                    accept;

  always_comb begin
    free_onehot = '0;
    // Scan downward so the lowest inactive index wins.
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end
    end
    accept = frame_tick && !clear && fire && (state == READY) && (free_onehot != '0);
    spawn  = accept ? free_onehot : '0;
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_BULLETS; i++) active_count = active_count + 4'(active[i]);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= READY;
      cooldown <= '0;
      fire_ack <= 1'b0;
    end else if (clear) begin
      state    <= READY;
      cooldown <= '0;
      fire_ack <= 1'b0;
    end else begin
      fire_ack <= accept;
      if (accept) begin
        cooldown <= CW'(COOLDOWN);
        state    <= (COOLDOWN == 0) ? READY : COOLING;
      end else if (frame_tick && state == COOLING) begin
        cooldown <= cooldown - CW'(1);
        if (cooldown <= CW'(1)) state <= READY;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
      bullet_slot #(.LIFETIME(LIFETIME)) u_slot (
        .CLK        (CLK),
        .RESET      (RESET),
        .frame_tick (frame_tick),
        .clear      (clear),
        .spawn      (spawn[gi]),
        .spawn_x    (tank_x),
        .spawn_y    (tank_y),
        .spawn_vx   (cos),
        .spawn_vy   (sin),
        .wall_hit   (wall_hit[gi*4 +: 4]),
        .active     (active[gi]),
        .bullet_x   (bullet_x[gi*PIX_W +: PIX_W]),
        .bullet_y   (bullet_y[gi*PIX_W +: PIX_W])
      );
    end
  endgenerate
endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: directed scenarios plus randomized frames against an integer-arithmetic model.
module tb_bullet_pool;
  localparam int N  = 3;
  localparam int LT = 300;
  localparam int CD = 35;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              frame_tick = 1'b0;
  logic              clear = 1'b0;
  logic              fire = 1'b0;
  logic [9:0]        tank_x = '0;
  logic [9:0]        tank_y = '0;
  logic signed [7:0] head_sin = '0;
  logic signed [7:0] head_cos = '0;
  logic [N*4-1:0]    wall_hit = '0;
  logic [N*10-1:0]   bullet_x, bullet_y;
  logic [N-1:0]      active;
  logic              fire_ack;
  logic [3:0]        active_count;

  int checks = 0;
  int errors = 0;

  // Model state: positions in 1/64 pixel, plain ints.
  int m_x[N], m_y[N], m_vx[N], m_vy[N], m_t[N];
  bit m_act[N];
  int m_cd;
  bit m_ready;
  bit m_ack;

  bullet_pool #(.NUM_BULLETS(N), .LIFETIME(LT), .COOLDOWN(CD)) dut (
    .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .clear(clear), .fire(fire),
    .tank_x(tank_x), .tank_y(tank_y), .sin(head_sin), .cos(head_cos), .wall_hit(wall_hit),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .active(active), .fire_ack(fire_ack),
    .active_count(active_count)
  );

  always #10 CLK = ~CLK;

  initial begin
    #20ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic int sneg(input int v);
    return (v == -128) ? 127 : -v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_t[i] = 0;
    end
    m_cd = 0; m_ready = 1; m_ack = 0;
  endtask

  // Drive one cycle (called at negedge), advance the model by the game rules, return at next negedge.
  task automatic step(input bit tk, input bit clr);
    int slot;
    bit acc;
    slot = -1;
    frame_tick = tk;
    clear = clr;
    if (clr) begin
      for (int i = 0; i < N; i++) m_act[i] = 0;
      m_ready = 1; m_cd = 0; m_ack = 0;
    end else if (tk) begin
      for (int i = 0; i < N; i++) if (!m_act[i] && slot < 0) slot = i;
      acc = fire && m_ready && (slot >= 0);
      for (int i = 0; i < N; i++) begin
        if (m_act[i]) begin
          if (wall_hit[i*4+3] || wall_hit[i*4+2]) m_vx[i] = sneg(m_vx[i]);
          if (wall_hit[i*4+1] || wall_hit[i*4+0]) m_vy[i] = sneg(m_vy[i]);
          m_x[i] += m_vx[i];
          m_y[i] += m_vy[i];
          m_t[i] -= 1;
          if (m_t[i] == 0 || m_x[i] < 0 || m_x[i] >= 640*64 || m_y[i] < 0 || m_y[i] >= 480*64)
            m_act[i] = 0;
        end
      end
      if (acc) begin
        m_x[slot] = int'(tank_x) * 64;
        m_y[slot] = int'(tank_y) * 64;
        m_vx[slot] = int'(head_cos);
        m_vy[slot] = int'(head_sin);
        m_t[slot] = LT;
        m_act[slot] = 1;
        m_cd = CD;
        m_ready = (CD == 0);
      end else if (!m_ready) begin
        m_cd -= 1;
        if (m_cd == 0) m_ready = 1;
      end
      m_ack = acc;
    end else begin
      m_ack = 0;
    end
    @(posedge CLK);
    @(negedge CLK);
    frame_tick = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++; if (active !== '0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
    checks++; if (fire_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", fire_ack); end
    checks++; if (active_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", active_count); end
    checks++; if (bullet_x !== '0 || bullet_y !== '0) begin errors++; $display("FAIL reset_pos got %h/%h want 0", bullet_x, bullet_y); end
    RESET = 1'b1;
    model_reset();
    @(negedge CLK);
    $display("test_reset done");
  endtask

  task automatic test_spawn_move();
    fire = 1; tank_x = 100; tank_y = 200; head_cos = 64; head_sin = 0;
    step(1, 0);
    checks++; if (fire_ack !== 1'b1) begin errors++; $display("FAIL spawn_ack got %b want 1", fire_ack); end
    checks++; if (active[0] !== 1'b1) begin errors++; $display("FAIL spawn_active got %b want 1", active[0]); end
    checks++; if (bullet_x[9:0] !== 10'd100 || bullet_y[9:0] !== 10'd200) begin errors++;
      $display("FAIL spawn_pos got (%0d,%0d) want (100,200)", bullet_x[9:0], bullet_y[9:0]); end
    fire = 0;
    step(1, 0);
    checks++; if (bullet_x[9:0] !== 10'd101 || bullet_y[9:0] !== 10'd200) begin errors++;
      $display("FAIL move_pos got (%0d,%0d) want (101,200)", bullet_x[9:0], bullet_y[9:0]); end
    checks++; if (fire_ack !== 1'b0) begin errors++; $display("FAIL move_ack got %b want 0", fire_ack); end
    step(0, 0);
    checks++; if (bullet_x[9:0] !== 10'd101) begin errors++; $display("FAIL hold_pos got %0d want 101", bullet_x[9:0]); end
    $display("test_spawn_move done");
  endtask

  task automatic test_cooldown();
    step(0, 1);
    fire = 1; tank_x = 300; tank_y = 300; head_cos = 0; head_sin = 0;
    for (int t = 1; t <= 40; t++) begin
      step(1, 0);
      checks++;
      if (fire_ack !== ((t == 1) || (t == 37))) begin errors++;
        $display("FAIL cooldown_ack tick %0d got %b want %b", t, fire_ack, (t == 1) || (t == 37)); end
      if (t == 37) begin
        checks++; if (active_count !== 4'd2) begin errors++; $display("FAIL cooldown_count got %0d want 2", active_count); end
      end
    end
    fire = 0;
    $display("test_cooldown done");
  endtask

  task automatic test_full_pool();
    step(0, 1);
    fire = 1; tank_x = 50; tank_y = 50; head_cos = 0; head_sin = 0;
    for (int t = 1; t <= 400; t++) begin
      step(1, 0);
      checks++;
      if (fire_ack !== (t == 1 || t == 37 || t == 73 || t == 302 || t == 338 || t == 374)) begin errors++;
        $display("FAIL pool_ack tick %0d got %b", t, fire_ack); end
      if (t == 337) begin
        checks++; if (active !== 3'b101) begin errors++; $display("FAIL pool_expire got %b want 101", active); end
      end
      if (t == 338) begin
        checks++; if (active !== 3'b111) begin errors++; $display("FAIL pool_refill got %b want 111", active); end
      end
    end
    fire = 0;
    $display("test_full_pool done");
  endtask

  task automatic test_bounce();
    step(0, 1);
    fire = 1; tank_x = 320; tank_y = 240; head_cos = 64; head_sin = 0;
    step(1, 0);
    fire = 0; wall_hit = 12'b0000_0000_0100;
    step(1, 0);
    checks++; if (bullet_x[9:0] !== 10'd319) begin errors++; $display("FAIL bounce_right got %0d want 319", bullet_x[9:0]); end
    wall_hit = '0;
    step(1, 0);
    checks++; if (bullet_x[9:0] !== 10'd318) begin errors++; $display("FAIL bounce_persist got %0d want 318", bullet_x[9:0]); end
    step(0, 1);
    fire = 1; head_cos = -128;
    step(1, 0);
    fire = 0; wall_hit = 12'b0000_0000_1000;
    step(1, 0);
    checks++; if (bullet_x[9:0] !== 10'd321) begin errors++; $display("FAIL bounce_sat1 got %0d want 321", bullet_x[9:0]); end
    wall_hit = '0;
    step(1, 0);
    checks++; if (bullet_x[9:0] !== 10'd323) begin errors++; $display("FAIL bounce_sat2 got %0d want 323", bullet_x[9:0]); end
    $display("test_bounce done");
  endtask

  task automatic test_clear_vs_fire();
    step(0, 1);
    fire = 1; tank_x = 200; tank_y = 100; head_cos = 0; head_sin = 0;
    step(1, 0);
    step(1, 1);
    checks++; if (active !== '0) begin errors++; $display("FAIL clear_active got %b want 0", active); end
    checks++; if (fire_ack !== 1'b0) begin errors++; $display("FAIL clear_ack got %b want 0", fire_ack); end
    step(1, 0);
    checks++; if (fire_ack !== 1'b1) begin errors++; $display("FAIL clear_ready got %b want 1", fire_ack); end
    fire = 0;
    $display("test_clear_vs_fire done");
  endtask

  task automatic test_edge();
    step(0, 1);
    fire = 1; tank_x = 639; tank_y = 10; head_cos = 64; head_sin = 0;
    step(1, 0);
    checks++; if (active[0] !== 1'b1 || bullet_x[9:0] !== 10'd639) begin errors++;
      $display("FAIL edge_spawn got act %b x %0d want 1 639", active[0], bullet_x[9:0]); end
    fire = 0;
    step(1, 0);
    checks++; if (active[0] !== 1'b0) begin errors++; $display("FAIL edge_right got %b want 0", active[0]); end
    step(0, 1);
    fire = 1; tank_x = 0; head_cos = -1;
    step(1, 0);
    fire = 0;
    step(1, 0);
    checks++; if (active[0] !== 1'b0) begin errors++; $display("FAIL edge_left got %b want 0", active[0]); end
    $display("test_edge done");
  endtask

  task automatic test_random();
    int pop;
    step(0, 1);
    for (int n = 0; n < 300; n++) begin
      fire     = 1'($urandom_range(0, 1));
      tank_x   = 10'($urandom_range(0, 639));
      tank_y   = 10'($urandom_range(0, 479));
      head_cos = 8'($urandom);
      head_sin = 8'($urandom);
      wall_hit = N*4'($urandom & $urandom & $urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      checks++; if (fire_ack !== m_ack) begin errors++; $display("FAIL rand_ack n %0d got %b want %b", n, fire_ack, m_ack); end
      pop = 0;
      for (int i = 0; i < N; i++) begin
        pop += int'(m_act[i]);
        checks++; if (active[i] !== m_act[i]) begin errors++;
          $display("FAIL rand_active n %0d slot %0d got %b want %b", n, i, active[i], m_act[i]); end
        if (m_act[i]) begin
          checks++;
          if (bullet_x[i*10 +: 10] !== 10'(m_x[i] >> 6) || bullet_y[i*10 +: 10] !== 10'(m_y[i] >> 6)) begin errors++;
            $display("FAIL rand_pos n %0d slot %0d got (%0d,%0d) want (%0d,%0d)", n, i,
                     bullet_x[i*10 +: 10], bullet_y[i*10 +: 10], m_x[i] >> 6, m_y[i] >> 6); end
        end
      end
      checks++; if (active_count !== 4'(pop)) begin errors++; $display("FAIL rand_count n %0d got %0d want %0d", n, active_count, pop); end
    end
    fire = 0; wall_hit = '0;
    $display("test_random done");
  endtask

  task automatic test_reset_midflight();
    step(0, 1);
    fire = 1; tank_x = 400; tank_y = 300; head_cos = 10; head_sin = 5;
    step(1, 0);
    fire = 0;
    step(1, 0);
    RESET = 1'b0;
    #1;
    checks++; if (active !== '0 || fire_ack !== 1'b0 || active_count !== 4'd0) begin errors++;
      $display("FAIL midreset_flags got act %b ack %b cnt %0d want 0", active, fire_ack, active_count); end
    checks++; if (bullet_x !== '0 || bullet_y !== '0) begin errors++;
      $display("FAIL midreset_pos got %h/%h want 0", bullet_x, bullet_y); end
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
    fire = 1;
    step(1, 0);
    checks++; if (fire_ack !== 1'b1 || active !== 3'b001) begin errors++;
      $display("FAIL midreset_first got ack %b act %b want 1 001", fire_ack, active); end
    fire = 0;
    $display("test_reset_midflight done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_spawn_move();
    test_cooldown();
    test_full_pool();
    test_bounce();
    test_clear_vs_fire();
    test_edge();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
